// File: rtl/mc_mem_fetch_unit.sv
// rtl/mc_mem_fetch_unit.sv - PC/IR/load-data registers and memory access controller for the multicycle RV32 core
// Optional feature macro: MISALIGN_CHECK_EN (trap word-misaligned accesses, sticky misalign_err).
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   pc_update, branch, zero, we_ir, mem_rd, we_mem, sel_mem_addr : control from the main FSM
//   result, wdata     : next-PC / data address bus, store data
//   pc, old_pc, instr, data, op : architectural registers and opcode back to the FSM
//   stall             : hold request to the FSM while an access is in flight
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready : memory port
//   misalign_err      : sticky misaligned-access flag
module mc_mem_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_update,
  input  logic            branch,
  input  logic            zero,
  input  logic            we_ir,
  input  logic            mem_rd,
  input  logic            we_mem,
  input  logic            sel_mem_addr,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] data,
  output logic [6:0]      op,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  state_t          state;
  kind_t           kind;
  kind_t           win_kind;
  logic            strobe_any;
  logic            misaligned;
  logic [XLEN-1:0] sel_addr;

  assign strobe_any = we_ir | we_mem | mem_rd;
  assign sel_addr   = sel_mem_addr ? result : pc;
  assign op         = instr[6:0];

  // Fetch beats store beats load when the FSM raises several strobes at once.
  always_comb begin
    win_kind = K_LOAD;
    if (we_ir) begin
      win_kind = K_FETCH;
    end else if (we_mem) begin
      win_kind = K_STORE;
    end
  end

  // DONE deliberately drops stall so the FSM can leave the access state
  // while the still-asserted strobe is ignored.
  assign stall = rst & (((state == S_IDLE) & strobe_any) | (state == S_BUSY));

`ifdef MISALIGN_CHECK_EN
  logic err_q;

  assign misaligned   = (sel_addr[1:0] != 2'b00);
  assign misalign_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE) && strobe_any && misaligned) begin
      err_q <= 1'b1;
    end
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      kind      <= K_FETCH;
      pc        <= RESET_PC;
      old_pc    <= RESET_PC;
      instr     <= '0;
      data      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // A fetch holds stall until DONE, so PC moves exactly once per fetch.
      if ((pc_update | (branch & zero)) & ~stall) begin
        pc <= result;
      end

      case (state)
        S_IDLE: begin
          if (strobe_any) begin
            kind <= win_kind;
            if (misaligned) begin
              state <= S_DONE;
            end else begin
              state     <= S_BUSY;
              mem_req   <= 1'b1;
              mem_addr  <= sel_addr;
              mem_we    <= (win_kind == K_STORE);
              mem_wdata <= wdata;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (kind)
              K_FETCH: begin
                instr  <= mem_rdata;
                old_pc <= pc;
              end
              K_LOAD:  data <= mem_rdata;
              default: ;
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mem_fetch_unit.sv
// tb/tb_mc_mem_fetch_unit.sv - self-checking bench for mc_mem_fetch_unit
module tb_mc_mem_fetch_unit;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst, pc_update, branch, zero, we_ir, mem_rd, we_mem, sel_mem_addr, mem_ready;
  logic [31:0] result, wdata, mem_rdata;
  logic [31:0] pc, old_pc, instr, data, mem_addr, mem_wdata;
  logic [6:0]  op;
  logic        stall, mem_req, mem_we, misalign_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_pc, exp_old_pc, exp_instr, exp_data, exp_addr, exp_wd;
  logic        exp_stall, exp_req, exp_we, exp_mis;

  int          stall_cycles, req_cycles, req_rises;
  logic        prev_req, seen_we;
  logic [31:0] seen_wd;

  always #5 clk = ~clk;

  mc_mem_fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_update(pc_update), .branch(branch), .zero(zero),
    .we_ir(we_ir), .mem_rd(mem_rd), .we_mem(we_mem), .sel_mem_addr(sel_mem_addr),
    .result(result), .wdata(wdata), .pc(pc), .old_pc(old_pc), .instr(instr),
    .data(data), .op(op), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .misalign_err(misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // Per-cycle comparison of every output against the access-level model.
  task automatic compare_all();
    check("pc", pc, exp_pc);
    check("old_pc", old_pc, exp_old_pc);
    check("instr", instr, exp_instr);
    check("data", data, exp_data);
    check("op", {25'b0, op}, {25'b0, exp_instr[6:0]});
    check1("stall", stall, exp_stall);
    check1("mem_req", mem_req, exp_req);
    check1("misalign_err", misalign_err, exp_mis);
    if (exp_req) begin
      check("mem_addr", mem_addr, exp_addr);
      check1("mem_we", mem_we, exp_we);
      check("mem_wdata", mem_wdata, exp_wd);
      seen_we = mem_we;
      seen_wd = mem_wdata;
    end
    if (stall) stall_cycles++;
    if (mem_req) req_cycles++;
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
  endtask

  // One FSM state: strobes held for the whole state; memory answers lat cycles
  // after launch. Expected outputs follow from the access timeline:
  // launch cycle stalls, request cycles 1..lat, DONE at lat+1.
  task automatic run_state(input logic s_ir, input logic s_st, input logic s_ld,
                           input logic s_sel, input logic s_pcu, input logic s_br,
                           input logic s_z, input logic [31:0] s_res,
                           input logic [31:0] s_wd, input int lat,
                           input logic [31:0] rd);
    logic        acc, mis, pcw;
    logic [31:0] addr;
    int          ncyc;
    acc  = s_ir | s_st | s_ld;
    addr = s_sel ? s_res : exp_pc;
    mis  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis  = acc && (addr[1:0] != 2'b00);
`endif
    ncyc = !acc ? 1 : (mis ? 2 : lat + 2);
    stall_cycles = 0; req_cycles = 0; req_rises = 0;
    prev_req = 1'b0; seen_we = 1'b0; seen_wd = 32'h0;
    we_ir = s_ir; we_mem = s_st; mem_rd = s_ld; sel_mem_addr = s_sel;
    pc_update = s_pcu; branch = s_br; zero = s_z; result = s_res; wdata = s_wd;
    for (int c = 0; c < ncyc; c++) begin
      exp_stall = acc && (c == 0 || (!mis && c <= lat));
      exp_req   = acc && !mis && c >= 1 && c <= lat;
      exp_addr  = addr;
      exp_we    = s_st && !s_ir;
      exp_wd    = s_wd;
      // Stray ready pulses in IDLE and DONE must be ignored.
      mem_ready = !acc || (!mis && (c == lat || c == ncyc - 1));
      mem_rdata = (acc && !mis && c == lat) ? rd : (32'hBAD0_0000 | 32'(c));
      pcw       = (s_pcu || (s_br && s_z)) && !exp_stall;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
      if (acc && !mis && c == lat) begin
        if (s_ir) begin
          exp_instr  = rd;
          exp_old_pc = exp_pc;
        end else if (!s_st) begin
          exp_data = rd;
        end
      end
      if (mis) exp_mis = 1'b1;
      if (pcw) exp_pc = s_res;
    end
    we_ir = 1'b0; we_mem = 1'b0; mem_rd = 1'b0;
    pc_update = 1'b0; branch = 1'b0; zero = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we_ir = 1'b1; mem_rd = 1'b0; we_mem = 1'b0; pc_update = 1'b1;
    branch = 1'b0; zero = 1'b0; sel_mem_addr = 1'b0; result = 32'h55;
    wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check1("reset_stall_forced_low", stall, 1'b0);
    check("reset_pc", pc, 32'h100);
    check("reset_old_pc", old_pc, 32'h100);
    check("reset_instr", instr, 32'h0);
    check("reset_data", data, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check1("reset_mem_req", mem_req, 1'b0);
    check1("reset_mem_we", mem_we, 1'b0);
    check1("reset_misalign", misalign_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; we_ir = 1'b0; pc_update = 1'b0; result = 32'h0;
    exp_pc = RPC; exp_old_pc = RPC; exp_instr = 32'h0; exp_data = 32'h0; exp_mis = 1'b0;

    // Fetch, ready in the first request cycle.
    run_state(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 1, 32'h00500093);
    check("fetch_stall_cycles", 32'(stall_cycles), 32'd2);
    check("fetch_instr", instr, 32'h00500093);
    check("fetch_op", {25'b0, op}, 32'h13);
    check("fetch_old_pc", old_pc, 32'h100);
    check("fetch_pc", pc, 32'h104);

    // Load with four request cycles.
    run_state(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, 4, 32'h12345678);
    check("load_data", data, 32'h12345678);
    check("load_req_cycles", 32'(req_cycles), 32'd4);
    check("load_req_count", 32'(req_rises), 32'd1);
    check("load_stall_cycles", 32'(stall_cycles), 32'd5);

    // Store.
    run_state(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2004, 32'hDEADBEEF, 2, 32'h0);
    check1("store_we", seen_we, 1'b1);
    check("store_wdata", seen_wd, 32'hDEADBEEF);
    check("store_instr_kept", instr, 32'h00500093);
    check("store_data_kept", data, 32'h12345678);

    // All three strobes: fetch wins.
    run_state(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h11111111, 3, 32'h00a00113);
    check("prio_fetch_instr", instr, 32'h00a00113);
    check("prio_fetch_old_pc", old_pc, 32'h104);
    check("prio_fetch_pc", pc, 32'h108);
    check("prio_fetch_data_kept", data, 32'h12345678);
    check1("prio_fetch_we", seen_we, 1'b0);

    // Store beats load.
    run_state(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2010, 32'hCAFEF00D, 1, 32'h77777777);
    check1("prio_store_we", seen_we, 1'b1);
    check("prio_store_data_kept", data, 32'h12345678);

    // Branch taken / not taken, then JAL-style update.
    run_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 0, 32'h0);
    check("branch_taken_pc", pc, 32'h80);
    check("branch_stall_cycles", 32'(stall_cycles), 32'd0);
    run_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0);
    check("branch_not_taken_pc", pc, 32'h80);
    run_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 0, 32'h0);
    check("jal_pc", pc, 32'h300);

    // Misaligned load, then an aligned one.
    run_state(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2002, 32'h0, 2, 32'h55AA55AA);
`ifdef MISALIGN_CHECK_EN
    check("misalign_data_kept", data, 32'h12345678);
    check1("misalign_flag", misalign_err, 1'b1);
    check("misalign_no_req", 32'(req_rises), 32'd0);
`else
    check("unaligned_load_data", data, 32'h55AA55AA);
    check1("misalign_tied_low", misalign_err, 1'b0);
    check("unaligned_req_count", 32'(req_rises), 32'd1);
`endif
    run_state(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2008, 32'h0, 1, 32'h01020304);
    check("aligned_load_data", data, 32'h01020304);
`ifdef MISALIGN_CHECK_EN
    check1("misalign_sticky", misalign_err, 1'b1);
`else
    check1("misalign_still_low", misalign_err, 1'b0);
`endif

    // Reset during the BUSY phase of a fetch.
    we_ir = 1'b1; pc_update = 1'b1; sel_mem_addr = 1'b0; result = 32'h304; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check1("abort_req_busy", mem_req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1("abort_stall_in_reset", stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; we_ir = 1'b0; pc_update = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check1("abort_req_dropped", mem_req, 1'b0);
    check("abort_pc", pc, 32'h100);
    check("abort_old_pc", old_pc, 32'h100);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_instr_zero", instr, 32'h0);
    check("abort_data_zero", data, 32'h0);
    check1("abort_no_stall", stall, 1'b0);
    check1("abort_misalign_cleared", misalign_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_mem_fetch_unit.md
# mc_mem_fetch_unit

Architectural-state and memory-interface unit for the multicycle RV32 core, directly downstream of the main control FSM. It holds PC, OldPC, the instruction register and the load-data register, and returns `op` to the FSM. It runs fetch, load and store accesses to a unified variable-latency memory over a req/ready handshake. While an access is outstanding it asserts `stall` so the FSM holds its state.

## Interface
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: PC and OldPC value after reset.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `pc_update` in 1: unconditional PC write request from the FSM.
- `branch` in 1: branch state indicator from the FSM.
- `zero` in 1: ALU zero flag.
- `we_ir` in 1: fetch strobe; the FSM holds it for the whole fetch state.
- `mem_rd` in 1: load strobe, asserted by the FSM in the memory-read state only.
- `we_mem` in 1: store strobe.
- `sel_mem_addr` in 1: address select; 0 = PC, 1 = `result`.
- `result` in XLEN: result bus; carries the next-PC value and the data address.
- `wdata` in XLEN: store data (rs2 register).
- `pc`, `old_pc`, `instr`, `data` out XLEN: architectural registers.
- `op` out 7: `instr[6:0]`.
- `stall` out 1: FSM hold request.
- `mem_req`, `mem_we` out 1: memory request and write enable.
- `mem_addr`, `mem_wdata` out XLEN: latched request address and store data.
- `mem_rdata` in XLEN, `mem_ready` in 1: memory response.
- `misalign_err` out 1: sticky error flag (see Configuration).

## Operation
- Access controller states:
  - IDLE → BUSY when a strobe (`we_ir`, `we_mem`, `mem_rd`) is seen in IDLE. This is the launch.
  - BUSY → DONE on `mem_ready`.
  - DONE → IDLE unconditionally.
- Strobe priority when several are asserted: `we_ir` > `we_mem` > `mem_rd`. Only the winning access is performed.
- Strobes seen in DONE are ignored. This prevents relaunch while the FSM is still in the same state.
- At launch the unit latches:
  - `mem_addr` ← `sel_mem_addr ? result : pc`.
  - `mem_we` ← store.
  - `mem_wdata` ← `wdata`.
  - The access kind.
- The latched values stay stable while `mem_req` = 1.
- `mem_req` is registered. It is 1 throughout BUSY and drops in the cycle after `mem_ready` is sampled.
- On `mem_ready` in BUSY:
  - Fetch: `instr` ← `mem_rdata`, `old_pc` ← `pc`.
  - Load: `data` ← `mem_rdata`.
  - Store: no register write.
- `stall` is combinational: `(IDLE & any strobe) | BUSY`. It is 0 in DONE, and forced to 0 while `rst` = 0.
- PC write: `pc` ← `result` when `(pc_update | (branch & zero)) & !stall`.
  - A fetch therefore advances PC exactly once, in its DONE cycle.
  - Branch and JAL states have no access, so they write PC in their single cycle.
- `op` is always `instr[6:0]`.

## Timing
- Reset values: `pc` = `old_pc` = `RESET_PC`; `instr`, `data`, `mem_addr`, `mem_wdata` = 0; `mem_req` = `mem_we` = 0; state = IDLE; `misalign_err` = 0.
- Launch cycle t: `stall` = 1.
- Cycle t+1: `mem_req` = 1.
- With `mem_ready` first high in cycle t+k (k ≥ 1):
  - Cycle t+k+1 is DONE: `stall` = 0, `instr`/`data` updated and visible.
  - The FSM advances at the end of t+k+1.
- Minimum occupancy is 3 cycles per access state.
- `mem_ready` outside BUSY is ignored.
- Reset mid-access:
  - The unit returns to IDLE and `mem_req` drops next cycle.
  - The memory must tolerate an abandoned request.
  - No register is written from the abandoned response.
- `pc_update` with no strobe (e.g. the JAL state): PC is written the same cycle with no stall.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - At launch, if the selected address has `[1:0] != 0`, the unit sets `misalign_err` (sticky until reset).
  - No `mem_req` is issued; the controller goes IDLE → DONE directly.
  - `instr`/`data`/`old_pc` are unchanged and memory is not written.
  - A fetch still advances PC in DONE.
- `MISALIGN_CHECK_EN` undefined: addresses pass unmodified and `misalign_err` is tied to 0.

## Test plan
- Reset with `RESET_PC` = 32'h100, then fetch with `mem_ready` 1 cycle after `mem_req` and `mem_rdata` = 32'h00500093:
  - `stall` = 1 for 2 cycles.
  - Then `instr` = 32'h00500093, `op` = 7'h13, `old_pc` = 32'h100.
  - `pc` = `result` (32'h104) after DONE.
- Load at `result` = 32'h2000 with `mem_ready` delayed 4 cycles:
  - `mem_addr` is stable at 32'h2000 and `mem_req` stays high for 4 cycles.
  - `data` = `mem_rdata`; exactly one request is issued.
- Store with `wdata` = 32'hDEADBEEF at 32'h2004: `mem_we` = 1, `mem_wdata` = 32'hDEADBEEF; `instr` and `data` are unchanged.
- Branch state with `zero` = 1 and `result` = 32'h80: `pc` = 32'h80 next cycle with `stall` = 0. Repeating with `zero` = 0 leaves `pc` unchanged.
- `rst` low during BUSY of a fetch: `mem_req` = 0 and `pc` = `RESET_PC`. A late `mem_ready` leaves `instr` = 0.
- `MISALIGN_CHECK_EN`: load at 32'h2002 gives `misalign_err` = 1, no `mem_req`, `data` unchanged; `misalign_err` stays 1 through later accesses.
